vga_sync_gen: RTL and testbench

- Upstream timing stage of the VGA signal generator.
- Produces horizontal/vertical counters, pixel coordinates, the active-area flag and hsync/vsync for a 640x480@60 raster.
- Drives coord_x, coord_y and active_area of the pattern/graphics stage, which registers rgb one clk later.
- Provides hsync/vsync delayed by SYNC_DELAY clks so they align with that registered rgb at the connector.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_sync_delay.sv | 28 ++
 rtl/vga_sync_gen.sv | 99 +++++++++
 tb/tb_vga_sync_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants for the sync and graphics stages
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_H_TOTAL      = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL      = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    typedef logic [COORD_W-1:0] coord_t;

    // True when pos lies in the half-open window [lo, hi).
    function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: N-stage 2-bit shift register that aligns sideband bits with the pixel pipeline
module vga_sync_delay #(
    parameter int         N       = 1,
    parameter logic [1:0] RST_VAL = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    if (N == 0) begin : g_pass
        assign dout = din;
    end else begin : g_delay
        logic [1:0] stages [N];
        // shift din through N stages; reset parks every stage at the idle level
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < N; i++) stages[i] <= RST_VAL;
            end else begin
                stages[0] <= din;
                for (int i = 1; i < N; i++) stages[i] <= stages[i-1];
            end
        end
        assign dout = stages[N-1];
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters, coordinates, active flag and delayed hsync/vsync
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VIS      = VGA_H_VIS,
    parameter int   H_FP       = VGA_H_FP,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_BP       = VGA_H_BP,
    parameter int   V_VIS      = VGA_V_VIS,
    parameter int   V_FP       = VGA_V_FP,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_BP       = VGA_V_BP,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   CLK_DIV    = 1,
    parameter int   SYNC_DELAY = 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pixel_tick,
    output logic [COORD_W-1:0] coord_x,
    output logic [COORD_W-1:0] coord_y,
    output logic               active_area,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync
);

    localparam logic   INACT    = ~SYNC_POL;
    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam coord_t H_LAST   = COORD_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = COORD_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VIS_C  = COORD_W'(H_VIS);
    localparam coord_t V_VIS_C  = COORD_W'(V_VIS);
    localparam coord_t HS_START = COORD_W'(H_VIS + H_FP);
    localparam coord_t HS_END   = COORD_W'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VS_START = COORD_W'(V_VIS + V_FP);
    localparam coord_t VS_END   = COORD_W'(V_VIS + V_FP + V_SYNC);

    logic [1:0] div_cnt;
    coord_t     h_cnt, v_cnt, h_next, v_next;
    logic       h_wrap, v_wrap;
    logic       hs_raw, vs_raw;
    logic [1:0] sync_dly;

    assign coord_x = h_cnt;
    assign coord_y = v_cnt;

    // pixel divider: pixel_tick marks the last clk of each pixel, so counters step on the following edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
        end else begin
            div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            pixel_tick <= (div_cnt == DIV_LAST);
        end
    end

    // next raster position; every registered output decodes this so they stay aligned with coord
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_next = pixel_tick ? (h_wrap ? '0 : h_cnt + 1'b1) : h_cnt;
        v_next = (pixel_tick && h_wrap) ? (v_wrap ? '0 : v_cnt + 1'b1) : v_cnt;
    end

    // raster counters plus outputs registered from the next-count decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            active_area <= 1'b0;
            frame_start <= 1'b0;
            hs_raw      <= INACT;
            vs_raw      <= INACT;
        end else begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            active_area <= (h_next < H_VIS_C) && (v_next < V_VIS_C);
            frame_start <= pixel_tick && h_wrap && v_wrap;
            hs_raw      <= in_window(h_next, HS_START, HS_END) ? SYNC_POL : INACT;
            vs_raw      <= in_window(v_next, VS_START, VS_END) ? SYNC_POL : INACT;
        end
    end

    vga_sync_delay #(
        .N       (SYNC_DELAY),
        .RST_VAL ({INACT, INACT})
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   ({hs_raw, vs_raw}),
        .dout  (sync_dly)
    );

    assign hsync = sync_dly[1];
    assign vsync = sync_dly[0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks four vga_sync_gen configurations against a raster model every clk
module tb_vga_sync_gen;

    typedef struct packed {
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       fs;
        logic       hs;
        logic       vs;
    } vout_t;

    localparam int CD[4]   = '{1, 1, 2, 3};
    localparam int CSD[4]  = '{1, 0, 3, 4};
    localparam int CPOL[4] = '{0, 0, 0, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    int         k = 0;
    int         checks = 0;
    int         errors = 0;
    logic       pt [4];
    logic [9:0] cx [4];
    logic [9:0] cy [4];
    logic       act [4];
    logic       fs [4];
    logic       hs [4];
    logic       vs [4];
    vout_t      o [4];

    always #5 clk = ~clk;

    vga_sync_gen u_a (
        .clk(clk), .reset(reset), .pixel_tick(pt[0]), .coord_x(cx[0]), .coord_y(cy[0]),
        .active_area(act[0]), .frame_start(fs[0]), .hsync(hs[0]), .vsync(vs[0])
    );

    vga_sync_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .CLK_DIV(1), .SYNC_DELAY(0)
    ) u_b (
        .clk(clk), .reset(reset), .pixel_tick(pt[1]), .coord_x(cx[1]), .coord_y(cy[1]),
        .active_area(act[1]), .frame_start(fs[1]), .hsync(hs[1]), .vsync(vs[1])
    );

    vga_sync_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .CLK_DIV(2), .SYNC_DELAY(3)
    ) u_c (
        .clk(clk), .reset(reset), .pixel_tick(pt[2]), .coord_x(cx[2]), .coord_y(cy[2]),
        .active_area(act[2]), .frame_start(fs[2]), .hsync(hs[2]), .vsync(vs[2])
    );

    vga_sync_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .CLK_DIV(3), .SYNC_DELAY(4)
    ) u_d (
        .clk(clk), .reset(reset), .pixel_tick(pt[3]), .coord_x(cx[3]), .coord_y(cy[3]),
        .active_area(act[3]), .frame_start(fs[3]), .hsync(hs[3]), .vsync(vs[3])
    );

    always_comb begin
        for (int i = 0; i < 4; i++) o[i] = {pt[i], cx[i], cy[i], act[i], fs[i], hs[i], vs[i]};
    end

    // k = clk edges since reset release; 0 while in reset or before the first edge
    always @(posedge clk or negedge reset) begin
        if (!reset) k <= 0;
        else k <= k + 1;
    end

    // Raster model: k-th clk after release shows pixel n=(k-1)/d; syncs are that rule evaluated sd clks earlier.
    function automatic vout_t model(input int kk, input int d, input int sd, input int pol,
                                    input int hv, input int hf, input int hsw, input int hb,
                                    input int vv, input int vf, input int vsw, input int vb);
        vout_t r;
        int ht, vt, n, x, y, nd, xd, yd;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        r = '0;
        r.hs = (pol == 0);
        r.vs = (pol == 0);
        if (kk < 1) return r;
        n = (kk - 1) / d;
        x = n % ht;
        y = (n / ht) % vt;
        r.pt  = (kk % d == 0);
        r.x   = 10'(x);
        r.y   = 10'(y);
        r.act = (x < hv) && (y < vv);
        r.fs  = (n > 0) && (x == 0) && (y == 0) && ((kk - 1) % d == 0);
        if (kk - sd >= 1) begin
            nd = (kk - sd - 1) / d;
            xd = nd % ht;
            yd = (nd / ht) % vt;
            r.hs = ((xd >= hv + hf) && (xd < hv + hf + hsw)) ? (pol != 0) : (pol == 0);
            r.vs = ((yd >= vv + vf) && (yd < vv + vf + vsw)) ? (pol != 0) : (pol == 0);
        end
        return r;
    endfunction

    function automatic vout_t expect_of(input int i, input int kk);
        if (i == 0) return model(kk, CD[0], CSD[0], CPOL[0], 640, 16, 96, 48, 480, 10, 2, 33);
        return model(kk, CD[i], CSD[i], CPOL[i], 16, 2, 4, 3, 6, 1, 2, 2);
    endfunction

    task automatic chk(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s k=%0d actual %0d required %0d", name, k, actual, required);
        end
    endtask

    // every clk: all four DUTs against the model, plus hand-computed literals at chosen clks
    always @(negedge clk) begin
        vout_t e;
        for (int i = 0; i < 4; i++) begin
            e = expect_of(i, k);
            checks++;
            if (o[i] !== e) begin
                errors++;
                $display("FAIL dut%0d k=%0d actual %h required %h", i, k, o[i], e);
            end
        end
        if (!reset) begin
            chk("rst_a_x", int'(o[0].x), 0);
            chk("rst_a_act", int'(o[0].act), 0);
            chk("rst_a_hs", int'(o[0].hs), 1);
            chk("rst_d_vs", int'(o[3].vs), 0);
        end else begin
            case (k)
                1:   begin chk("a_x_first", int'(o[0].x), 0); chk("a_act_first", int'(o[0].act), 1);
                           chk("a_fs_first", int'(o[0].fs), 0); end
                58:  chk("d_hs_before", int'(o[3].hs), 0);
                59:  chk("d_hs_start", int'(o[3].hs), 1);
                176: chk("b_vs_start", int'(o[1].vs), 0);
                275: begin chk("b_x_last", int'(o[1].x), 24); chk("b_y_last", int'(o[1].y), 10); end
                276: begin chk("b_fs_wrap", int'(o[1].fs), 1); chk("b_x_wrap", int'(o[1].x), 0); end
                551: begin chk("c_fs_wrap", int'(o[2].fs), 1); chk("c_pt_551", int'(o[2].pt), 0); end
                552: begin chk("c_fs_hold", int'(o[2].fs), 0); chk("c_pt_552", int'(o[2].pt), 1); end
                641: begin chk("a_x_640", int'(o[0].x), 640); chk("a_act_640", int'(o[0].act), 0); end
                657: chk("a_hs_657", int'(o[0].hs), 1);
                658: chk("a_hs_658", int'(o[0].hs), 0);
                753: chk("a_hs_753", int'(o[0].hs), 0);
                754: chk("a_hs_754", int'(o[0].hs), 1);
                801: begin chk("a_x_801", int'(o[0].x), 0); chk("a_y_801", int'(o[0].y), 1);
                           chk("a_fs_801", int'(o[0].fs), 0); end
                default: ;
            endcase
        end
    end

    initial begin
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2000) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_a_x", int'(o[0].x), 0);
        chk("mid_rst_a_act", int'(o[0].act), 0);
        chk("mid_rst_c_hs", int'(o[2].hs), 1);
        chk("mid_rst_d_pt", int'(o[3].pt), 0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (1500) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
